// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter that shares one registered WIDTH-bit adder among NUM_REQ requesters.
// Each operation runs IDLE -> EXEC -> DONE, returning the sum with a one-cycle ack.
module nibble_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   op_a,
   input  logic [NUM_REQ*WIDTH-1:0]   op_b,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         ack,
   output logic [WIDTH-1:0]           sum,
   output logic                       carry,
   output logic                       busy
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [NUM_REQ-1:0] ONE_HOT_0   = NUM_REQ'(1);
   localparam logic [IDXW-1:0]    PTR_INIT    = IDXW'(NUM_REQ - 1);

   logic [1:0]         state;
   logic [IDXW-1:0]    ptr;
   logic [IDXW-1:0]    win_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;

   logic               win_found;
   logic [IDXW-1:0]    win_idx;
   logic [IDXW-1:0]    cand;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;

   // Search upward from ptr+1 with wraparound, so the last winner is checked last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDXW'((int'(ptr) + off) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDXW'(i)) begin
            sel_a = op_a[i*WIDTH +: WIDTH];
            sel_b = op_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Operands and winner are captured at grant, so later input changes cannot disturb the add.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= PTR_INIT;
         win_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         gnt   <= '0;
         ack   <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  gnt   <= ONE_HOT_0 << win_idx;
                  win_q <= win_idx;
                  a_q   <= sel_a;
                  b_q   <= sel_b;
                  state <= EXEC;
               end
            end
            EXEC: begin
               {carry, sum} <= {1'b0, a_q} + {1'b0, b_q};
               ack          <= gnt;
               state        <= DONE;
            end
            DONE: begin
               ack   <= '0;
               gnt   <= '0;
               ptr   <= win_q;
               state <= IDLE;
            end
            default: begin
               ack   <= '0;
               gnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
